// File: rtl/alu_arbiter_if.sv
// Bundles the request, ALU and response channels of alu_arbiter.
// The arbiter uses the slave view; the requesters and ALU use the master view.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req0_in0;
  logic [WIDTH-1:0] req0_in1;
  logic [4:0]       req0_sel;
  logic [WIDTH-1:0] req1_in0;
  logic [WIDTH-1:0] req1_in1;
  logic [4:0]       req1_sel;
  logic [WIDTH-1:0] alu_in0;
  logic [WIDTH-1:0] alu_in1;
  logic [4:0]       alu_sel;
  logic [WIDTH-1:0] alu_out;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic             busy;

  modport slave (
    input  req_valid, req0_in0, req0_in1, req0_sel,
           req1_in0, req1_in1, req1_sel, alu_out, resp_ready,
    output req_ready, alu_in0, alu_in1, alu_sel, resp_valid, resp_data, busy
  );

  modport master (
    output req_valid, req0_in0, req0_in1, req0_sel,
           req1_in0, req1_in1, req1_sel, alu_out, resp_ready,
    input  req_ready, alu_in0, alu_in1, alu_sel, resp_valid, resp_data, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between the execute stage (0) and the
// branch/AGU (1): IDLE grants and latches, EXEC drives the ALU, RESP returns.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] in0_q, in0_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [4:0]       sel_q, sel_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;

  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] req_in0 [2];
  logic [WIDTH-1:0] req_in1 [2];
  logic [4:0]       req_sel [2];

  assign req_in0[0] = bus.req0_in0;
  assign req_in1[0] = bus.req0_in1;
  assign req_sel[0] = bus.req0_sel;
  assign req_in0[1] = bus.req1_in0;
  assign req_in1[1] = bus.req1_in1;
  assign req_sel[1] = bus.req1_sel;

  // Under contention the requester not served last time wins.
  always_comb begin
    grant = 1'b0;
    case (bus.req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant_q;
      default: grant = 1'b0;
    endcase
  end

  assign accept = (state_q == IDLE) && (|bus.req_valid);

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign bus.req_ready[gi]  = accept && (grant == 1'(gi));
    assign bus.resp_valid[gi] = (state_q == RESP) && (owner_q == 1'(gi));
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    in0_d        = in0_q;
    in1_d        = in1_q;
    sel_d        = sel_q;
    resp_data_d  = resp_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          in0_d        = req_in0[grant];
          in1_d        = req_in1[grant];
          sel_d        = req_sel[grant];
          owner_d      = grant;
          last_grant_d = grant;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        resp_data_d = bus.alu_out;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.resp_ready[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
      in0_q        <= '0;
      in1_q        <= '0;
      sel_q        <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      in0_q        <= in0_d;
      in1_q        <= in1_d;
      sel_q        <= sel_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign bus.alu_in0   = in0_q;
  assign bus.alu_in1   = in1_q;
  assign bus.alu_sel   = sel_q;
  assign bus.resp_data = resp_data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter against a transaction-level model
// with a small behavioural ALU attached to its ALU ports.
module tb_alu_arbiter;
  localparam int W = 32;
  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  alu_arbiter_if #(.WIDTH(W)) bus ();
  alu_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [4:0] s);
    case (s)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return ~a ^ {{(W-5){1'b0}}, s};
    endcase
  endfunction

  assign bus.alu_out = alu_ref(bus.alu_in0, bus.alu_in1, bus.alu_sel);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic new_payload(input int r);
    if (r == 0) begin
      bus.req0_in0 = $urandom;
      bus.req0_in1 = $urandom;
      bus.req0_sel = 5'($urandom_range(0, 7));
    end else begin
      bus.req1_in0 = $urandom;
      bus.req1_in1 = $urandom;
      bus.req1_sel = 5'($urandom_range(0, 7));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 2'b00; bus.resp_ready = 2'b00;
    bus.req0_in0 = '0; bus.req0_in1 = '0; bus.req0_sel = '0;
    bus.req1_in0 = '0; bus.req1_in1 = '0; bus.req1_sel = '0;
    cyc(); cyc();
    vectors++; if (bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready: got %b want 00", bus.req_ready); end
    vectors++; if (bus.resp_valid !== 2'b00) begin miscompares++; $display("FAIL reset_resp_valid: got %b want 00", bus.resp_valid); end
    vectors++; if (bus.resp_data !== '0) begin miscompares++; $display("FAIL reset_resp_data: got %h want 0", bus.resp_data); end
    vectors++; if (bus.alu_in0 !== '0 || bus.alu_in1 !== '0) begin miscompares++; $display("FAIL reset_alu_in: got %h/%h want 0/0", bus.alu_in0, bus.alu_in1); end
    vectors++; if (bus.alu_sel !== 5'd0) begin miscompares++; $display("FAIL reset_alu_sel: got %h want 0", bus.alu_sel); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single_add();
    bus.req0_in0 = 32'd5; bus.req0_in1 = 32'd7; bus.req0_sel = OP_ADD;
    bus.req_valid = 2'b01;
    #1;
    vectors++; if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL add_req_ready: got %b want 01", bus.req_ready); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL add_busy_idle: got %b want 0", bus.busy); end
    cyc();
    bus.req_valid = 2'b00;
    #1;
    vectors++; if (bus.alu_in0 !== 32'd5 || bus.alu_in1 !== 32'd7) begin miscompares++; $display("FAIL add_alu_in: got %0d/%0d want 5/7", bus.alu_in0, bus.alu_in1); end
    vectors++; if (bus.alu_sel !== OP_ADD) begin miscompares++; $display("FAIL add_alu_sel: got %h want %h", bus.alu_sel, OP_ADD); end
    vectors++; if (bus.resp_valid !== 2'b00) begin miscompares++; $display("FAIL add_resp_early: got %b want 00", bus.resp_valid); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL add_busy_exec: got %b want 1", bus.busy); end
    cyc();
    vectors++; if (bus.resp_valid !== 2'b01) begin miscompares++; $display("FAIL add_resp_valid: got %b want 01", bus.resp_valid); end
    vectors++; if (bus.resp_data !== 32'd12) begin miscompares++; $display("FAIL add_resp_data: got %0d want 12", bus.resp_data); end
    bus.resp_ready = 2'b01;
    cyc();
    vectors++; if (bus.resp_valid !== 2'b00) begin miscompares++; $display("FAIL add_resp_clear: got %b want 00", bus.resp_valid); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL add_busy_done: got %b want 0", bus.busy); end
    bus.resp_ready = 2'b00;
    $display("single_add: req0 5+7 -> %0d", bus.resp_data);
  endtask

  task automatic test_contention();
    rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();
    bus.req0_in0 = 32'd3;  bus.req0_in1 = 32'd1;  bus.req0_sel = OP_SUB;
    bus.req1_in0 = 32'hF;  bus.req1_in1 = 32'h3C; bus.req1_sel = OP_AND;
    bus.req_valid = 2'b11;
    #1;
    vectors++; if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL cont_first_grant: got %b want 01", bus.req_ready); end
    cyc();
    bus.req_valid = 2'b10;
    #1;
    vectors++; if (bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL cont_exec_ready: got %b want 00", bus.req_ready); end
    cyc();
    vectors++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== 32'd2) begin miscompares++; $display("FAIL cont_resp0: got %b/%h want 01/2", bus.resp_valid, bus.resp_data); end
    bus.resp_ready = 2'b11;
    cyc();
    vectors++; if (bus.req_ready !== 2'b10) begin miscompares++; $display("FAIL cont_second_grant: got %b want 10", bus.req_ready); end
    cyc();
    bus.req_valid = 2'b00;
    cyc();
    vectors++; if (bus.resp_valid !== 2'b10 || bus.resp_data !== 32'h0C) begin miscompares++; $display("FAIL cont_resp1: got %b/%h want 10/c", bus.resp_valid, bus.resp_data); end
    cyc();
    vectors++; if (bus.resp_valid !== 2'b00 || bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL cont_once: got resp %b ready %b want 00/00", bus.resp_valid, bus.req_ready); end
    bus.resp_ready = 2'b00;
    $display("contention: req0 -> 2, req1 -> 0c");
  endtask

  task automatic test_sustained();
    logic [1:0]   exp_owner [$];
    logic [W-1:0] exp_data [$];
    int           grants [$];
    int           model_last = 1;  // requester 1 was served last in the contention test
    int           first = -1;
    int           last = -1;
    int           done = 0;
    int           acc;
    bus.resp_ready = 2'b11;
    new_payload(0); new_payload(1);
    bus.req_valid = 2'b11;
    for (int c = 0; c < 60 && done < 6; c++) begin
      acc = -1;
      #1;
      if (bus.req_ready !== 2'b00) begin
        int w;
        w = (bus.req_valid == 2'b11) ? 1 - model_last : (bus.req_valid[1] ? 1 : 0);
        vectors++; if (bus.req_ready !== (2'b01 << w)) begin miscompares++; $display("FAIL sust_grant: got %b want %b", bus.req_ready, 2'b01 << w); end
        model_last = w;
        grants.push_back(w);
        exp_owner.push_back(2'b01 << w);
        exp_data.push_back(w == 0 ? alu_ref(bus.req0_in0, bus.req0_in1, bus.req0_sel)
                                  : alu_ref(bus.req1_in0, bus.req1_in1, bus.req1_sel));
        if (first < 0) first = c;
        acc = w;
      end
      if (bus.resp_valid !== 2'b00) begin
        logic [1:0]   eo;
        logic [W-1:0] ed;
        eo = (exp_owner.size() > 0) ? exp_owner.pop_front() : 2'b00;
        ed = (exp_data.size() > 0) ? exp_data.pop_front() : '0;
        vectors++;
        if (bus.resp_valid !== eo || bus.resp_data !== ed) begin
          miscompares++;
          $display("FAIL sust_resp: got %b/%h want %b/%h", bus.resp_valid, bus.resp_data, eo, ed);
        end
        $display("sustained: op %0d owner %b data %h", done, bus.resp_valid, bus.resp_data);
        done++;
        last = c;
      end
      if (done < 6) begin
        @(posedge clk);
        #1;
        if (acc >= 0) new_payload(acc);
      end
    end
    cyc();
    bus.req_valid = 2'b00;
    bus.resp_ready = 2'b00;
    vectors++; if (done != 6) begin miscompares++; $display("FAIL sust_timeout: got %0d responses want 6", done); end
    vectors++; if (last - first + 1 != 18) begin miscompares++; $display("FAIL sust_cycles: got %0d want 18", last - first + 1); end
    vectors++; if (grants.size() != 6) begin miscompares++; $display("FAIL sust_grant_count: got %0d want 6", grants.size()); end
    for (int i = 0; i < grants.size(); i++) begin
      vectors++; if (grants[i] != i % 2) begin miscompares++; $display("FAIL sust_order[%0d]: got %0d want %0d", i, grants[i], i % 2); end
    end
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL sust_busy_end: got %b want 0", bus.busy); end
  endtask

  task automatic test_backpressure();
    bus.req1_in0 = 32'hDEAD; bus.req1_in1 = 32'h0; bus.req1_sel = OP_ADD;
    bus.req_valid = 2'b10;
    #1;
    vectors++; if (bus.req_ready !== 2'b10) begin miscompares++; $display("FAIL bp_grant1: got %b want 10", bus.req_ready); end
    cyc();
    bus.req0_in0 = 32'd1; bus.req0_in1 = 32'd1; bus.req0_sel = OP_ADD;
    bus.req_valid = 2'b01;
    bus.resp_ready = 2'b01;
    cyc();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.resp_data !== 32'hDEAD || bus.resp_valid !== 2'b10 || bus.req_ready !== 2'b00) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got data %h valid %b ready %b want dead/10/00", i, bus.resp_data, bus.resp_valid, bus.req_ready);
      end
      cyc();
    end
    bus.resp_ready = 2'b11;
    #1;
    vectors++; if (bus.resp_valid !== 2'b10 || bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL bp_release: got %b/%b want 10/00", bus.resp_valid, bus.req_ready); end
    cyc();
    vectors++; if (bus.req_ready !== 2'b01 || bus.resp_valid !== 2'b00) begin miscompares++; $display("FAIL bp_next_grant: got ready %b resp %b want 01/00", bus.req_ready, bus.resp_valid); end
    cyc();
    bus.req_valid = 2'b00;
    cyc();
    vectors++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== 32'd2) begin miscompares++; $display("FAIL bp_resp0: got %b/%h want 01/2", bus.resp_valid, bus.resp_data); end
    cyc();
    bus.resp_ready = 2'b00;
    $display("backpressure: dead held 5 cycles, req0 -> 2");
  endtask

  task automatic test_reset_exec();
    bit seen = 1'b0;
    bus.req0_in0 = 32'd9; bus.req0_in1 = 32'd1; bus.req0_sel = OP_ADD;
    bus.req_valid = 2'b01;
    #1;
    vectors++; if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL rst_accept: got %b want 01", bus.req_ready); end
    cyc();
    bus.req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.alu_in0 !== '0 || bus.alu_in1 !== '0 || bus.alu_sel !== 5'd0) begin miscompares++; $display("FAIL rst_alu: got %h/%h/%h want 0/0/0", bus.alu_in0, bus.alu_in1, bus.alu_sel); end
    vectors++; if (bus.busy !== 1'b0 || bus.resp_valid !== 2'b00 || bus.resp_data !== '0) begin miscompares++; $display("FAIL rst_out: got busy %b resp %b data %h want 0/00/0", bus.busy, bus.resp_valid, bus.resp_data); end
    bus.resp_ready = 2'b11;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) rst_n = 1'b1;
      #1;
      if (bus.resp_valid !== 2'b00) seen = 1'b1;
      cyc();
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rst_no_resp: got resp seen %b want 0", seen); end
    bus.req1_in0 = 32'd4; bus.req1_in1 = 32'd4; bus.req1_sel = OP_XOR;
    bus.req_valid = 2'b11;
    #1;
    vectors++; if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL rst_contention: got %b want 01", bus.req_ready); end
    cyc();
    bus.req_valid = 2'b00;
    cyc();
    vectors++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== 32'd10) begin miscompares++; $display("FAIL rst_resp: got %b/%h want 01/a", bus.resp_valid, bus.resp_data); end
    cyc();
    bus.resp_ready = 2'b00;
    $display("reset_exec: in-flight op dropped, req0 -> %0d after reset", 10);
  endtask

  task automatic test_withdrawn();
    bit granted1 = 1'b0;
    bit busy_seen = 1'b0;
    bus.req0_in0 = 32'hF0; bus.req0_in1 = 32'h0F; bus.req0_sel = OP_OR;
    bus.req_valid = 2'b01;
    #1;
    vectors++; if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL wd_grant0: got %b want 01", bus.req_ready); end
    cyc();
    bus.req_valid = 2'b10;
    #1;
    vectors++; if (bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL wd_exec_ready: got %b want 00", bus.req_ready); end
    cyc();
    bus.resp_ready = 2'b01;
    #1;
    vectors++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== 32'hFF) begin miscompares++; $display("FAIL wd_resp0: got %b/%h want 01/ff", bus.resp_valid, bus.resp_data); end
    bus.req_valid = 2'b00;
    cyc();
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.req_ready[1] !== 1'b0) granted1 = 1'b1;
      if (bus.busy !== 1'b0) busy_seen = 1'b1;
      cyc();
    end
    vectors++; if (granted1 !== 1'b0) begin miscompares++; $display("FAIL wd_no_grant1: got %b want 0", granted1); end
    vectors++; if (busy_seen !== 1'b0) begin miscompares++; $display("FAIL wd_busy_idle: got %b want 0", busy_seen); end
    bus.resp_ready = 2'b00;
    $display("withdrawn: req1 never granted, busy idle");
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_contention();
    test_sustained();
    test_backpressure();
    test_reset_exec();
    test_withdrawn();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
